// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver: latches a hex word into shadow registers
// and walks one digit per prescaler slot, with optional leading-zero suppression.
`timescale 1ns/1ps

module seg7_scan_driver #(
    parameter int NDIG       = 4,
    parameter int DIV        = 50000,
    parameter int ACTIVE_LOW = 1,
    parameter int LZS        = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4*NDIG-1:0] value,
    input  logic [NDIG-1:0]   dp_in,
    input  logic [NDIG-1:0]   blank,
    input  logic              load,
    output logic [NDIG-1:0]   an,
    output logic [6:0]        seg,
    output logic              dp
);

    localparam int            IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int            PW   = $clog2(DIV);
    localparam logic [PW-1:0] TERM = PW'(DIV - 1);
    localparam logic          INV  = (ACTIVE_LOW != 0);

    logic [PW-1:0]     presc;
    logic [IW-1:0]     idx;
    logic              tick;
    logic [4*NDIG-1:0] value_q;
    logic [NDIG-1:0]   dp_q;
    logic [NDIG-1:0]   blank_q;
    logic [NDIG-1:0]   hide;
    logic [NDIG-1:0]   an_hot;
    logic [3:0]        nib;
    logic              cur_hide;
    logic              cur_dp;

    function automatic logic [6:0] seg7_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h7E;
            4'h1: s = 7'h30;
            4'h2: s = 7'h6D;
            4'h3: s = 7'h79;
            4'h4: s = 7'h33;
            4'h5: s = 7'h5B;
            4'h6: s = 7'h5F;
            4'h7: s = 7'h70;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h7B;
            4'hA: s = 7'h77;
            4'hB: s = 7'h1F;
            4'hC: s = 7'h4E;
            4'hD: s = 7'h3D;
            4'hE: s = 7'h4F;
            default: s = 7'h47;
        endcase
        return s;
    endfunction

    assign tick = (presc == TERM);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk) begin
        if (rst)       presc <= '0;
        else if (tick) presc <= '0;
        else           presc <= presc + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
        end else if (tick) begin
            if (NDIG == 1 || idx == IW'(NDIG - 1)) idx <= '0;
            else                                   idx <= idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
            dp_q    <= '0;
            blank_q <= '0;
        end else if (load) begin
            value_q <= value;
            dp_q    <= dp_in;
            blank_q <= blank;
        end
    end

    // Suppression scans from the top digit down; a requested dp stops it there.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        logic zero_run;
        logic dp_run;
        hide     = blank_q;
        zero_run = 1'b1;
        dp_run   = 1'b0;
        for (int k = NDIG - 1; k >= 1; k--) begin
            zero_run = zero_run & (value_q[4*k +: 4] == 4'h0);
            dp_run   = dp_run | dp_q[k];
            if (LZS != 0 && zero_run && !dp_run) hide[k] = 1'b1;
        end
    end

    always_comb begin
        nib      = 4'h0;
        cur_hide = 1'b0;
        cur_dp   = 1'b0;
        an_hot   = '0;
        for (int k = 0; k < NDIG; k++) begin
            if (idx == IW'(k)) begin
                nib       = value_q[4*k +: 4];
                cur_hide  = hide[k];
                cur_dp    = dp_q[k];
                an_hot[k] = 1'b1;
            end
        end
    end

    // Polarity is applied only here; everything upstream is high-true.
    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= {NDIG{INV}};
            seg <= {7{INV}};
            dp  <= INV;
        end else begin
            an  <= an_hot ^ {NDIG{INV}};
            seg <= (cur_hide ? 7'h00 : seg7_decode(nib)) ^ {7{INV}};
            dp  <= (cur_dp & ~cur_hide) ^ INV;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: two instances (LZS off / on) sharing stimulus,
// NDIG=4, DIV=4, low-true outputs.
`timescale 1ns/1ps

module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  blank;
    logic        load;
    logic [3:0]  an0, an1;
    logic [6:0]  seg0, seg1;
    logic        dp0, dp1;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic [6:0] seg_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                 7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    always #5 clk = ~clk;

    seg7_scan_driver #(.NDIG(4), .DIV(4), .ACTIVE_LOW(1), .LZS(0)) u_dut (
        .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .blank(blank), .load(load),
        .an(an0), .seg(seg0), .dp(dp0)
    );

    seg7_scan_driver #(.NDIG(4), .DIV(4), .ACTIVE_LOW(1), .LZS(1)) u_dut_lzs (
        .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .blank(blank), .load(load),
        .an(an1), .seg(seg1), .dp(dp1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // cyc counts cycles since the last reset release; cycle n starts at that release edge + n.
    task automatic wait_cycle(input int n);
        while (cyc < n) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    // Reset both instances, then load on the first post-reset edge; leaves cyc = 1.
    task automatic reset_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
        @(posedge clk); #1;
        rst = 1'b1; load = 1'b0; value = v; dp_in = d; blank = b;
        @(posedge clk); #1;
        @(negedge clk);
        check("in reset", 32'({an0, seg0, dp0, an1, seg1, dp1}), 32'h00FF_FFFF);
        @(posedge clk); #1;
        rst = 1'b0; load = 1'b1;
        @(negedge clk);
        check("first cycle after reset", 32'({an0, seg0, dp0, an1, seg1, dp1}), 32'h00FF_FFFF);
        @(posedge clk); #1;
        load  = 1'b0;
        value = ~v;
        cyc   = 1;
    endtask

    // One full 16-cycle revolution; expected seg words packed {d3,d2,d1,d0}, dp as output levels.
    task automatic scan_check(input string name,
                              input logic [27:0] s0, input logic [3:0] p0,
                              input logic [27:0] s1, input logic [3:0] p1);
        int d;
        logic [3:0] ea;
        for (int n = 2; n <= 17; n++) begin
            wait_cycle(n);
            @(negedge clk);
            d  = ((n - 1) / 4) % 4;
            ea = ~(4'b0001 << d);
            check($sformatf("%s c%0d an", name, n),      32'(an0),  32'(ea));
            check($sformatf("%s c%0d seg", name, n),     32'(seg0), 32'(s0[7*d +: 7]));
            check($sformatf("%s c%0d dp", name, n),      32'(dp0),  32'(p0[d]));
            check($sformatf("%s c%0d lzs an", name, n),  32'(an1),  32'(ea));
            check($sformatf("%s c%0d lzs seg", name, n), 32'(seg1), 32'(s1[7*d +: 7]));
            check($sformatf("%s c%0d lzs dp", name, n),  32'(dp1),  32'(p1[d]));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
        $fatal(1);
    end

    initial begin
        logic [3:0] nib;
        logic [6:0] e;
        logic [3:0] ea;
        rst = 1'b1; load = 1'b0; value = '0; dp_in = '0; blank = '0;

        reset_load(16'h1234, 4'b0000, 4'b0000);
        scan_check("h1234", {~7'h30, ~7'h6D, ~7'h79, ~7'h33}, 4'b1111,
                            {~7'h30, ~7'h6D, ~7'h79, ~7'h33}, 4'b1111);

        reset_load(16'h0050, 4'b0000, 4'b0000);
        scan_check("h0050", {~7'h7E, ~7'h7E, ~7'h5B, ~7'h7E}, 4'b1111,
                            { 7'h7F,  7'h7F, ~7'h5B, ~7'h7E}, 4'b1111);

        reset_load(16'h0000, 4'b0100, 4'b0000);
        scan_check("h0000 dp2", {~7'h7E, ~7'h7E, ~7'h7E, ~7'h7E}, 4'b1011,
                                { 7'h7F, ~7'h7E, ~7'h7E, ~7'h7E}, 4'b1011);

        reset_load(16'h1234, 4'b0011, 4'b0010);
        scan_check("blank d1", {~7'h30, ~7'h6D, 7'h7F, ~7'h33}, 4'b1110,
                               {~7'h30, ~7'h6D, 7'h7F, ~7'h33}, 4'b1110);

        for (int i = 0; i < 16; i++) begin
            nib = 4'(i);
            e   = ~seg_tab[i];
            reset_load({12'h000, nib}, 4'b0000, 4'b0000);
            wait_cycle(2);
            @(negedge clk);
            check($sformatf("sweep %h seg", nib),     32'(seg0), 32'(e));
            check($sformatf("sweep %h lzs seg", nib), 32'(seg1), 32'(e));
        end

        // Reset pulsed in the middle of the digit-2 slot.
        reset_load(16'h1234, 4'b0000, 4'b0000);
        wait_cycle(10);
        @(negedge clk);
        check("pre-abort an", 32'(an0), 32'(4'b1011));
        rst = 1'b1;
        wait_cycle(11);
        rst = 1'b0;
        @(negedge clk);
        check("abort outputs", 32'({an0, seg0, dp0, an1, seg1, dp1}), 32'h00FF_FFFF);
        e = ~7'h7E;
        for (int n = 12; n <= 16; n++) begin
            wait_cycle(n);
            @(negedge clk);
            ea = (n <= 15) ? 4'b1110 : 4'b1101;
            check($sformatf("restart c%0d an", n),  32'(an0),  32'(ea));
            check($sformatf("restart c%0d seg", n), 32'(seg0), 32'(e));
        end

        // Load landing on the slot tick that moves digit 1 -> digit 2.
        reset_load(16'h1234, 4'b0000, 4'b0000);
        wait_cycle(7);
        value = 16'hFFFF;
        load  = 1'b1;
        wait_cycle(8);
        load  = 1'b0;
        @(negedge clk);
        check("tick-load old an",  32'(an0),  32'(4'b1101));
        e = ~7'h79;
        check("tick-load old seg", 32'(seg0), 32'(e));
        e = ~7'h47;
        for (int n = 9; n <= 13; n++) begin
            wait_cycle(n);
            @(negedge clk);
            ea = (n <= 12) ? 4'b1011 : 4'b0111;
            check($sformatf("tick-load c%0d an", n),  32'(an0),  32'(ea));
            check($sformatf("tick-load c%0d seg", n), 32'(seg0), 32'(e));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter NDIG, default 4: number of multiplexed digits, legal range 1..8.
REQ-002 Parameter DIV, default 50000: clock cycles per digit slot, legal range 2..2^20.
REQ-003 Parameter ACTIVE_LOW, default 1: 1 = an/seg/dp are driven low-true (common-anode board); 0 = high-true.
REQ-004 Parameter LZS, default 0: 1 = leading-zero suppression enabled.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 value  in  4*NDIG  hex nibbles; nibble k (bits 4k+3:4k) is digit k; digit 0 is rightmost.
REQ-008 dp_in  in  NDIG  decimal-point request per digit.
REQ-009 blank  in  NDIG  per-digit forced blank.
REQ-010 load  in  1  one-cycle strobe; latches value, dp_in and blank into shadow registers.
REQ-011 an  out  NDIG  digit enables; exactly one asserted outside reset.
REQ-012 seg  out  7  segments, seg[6]=a through seg[0]=g.
REQ-013 dp  out  1  decimal-point segment.

Function
REQ-014 Shadow registers SHALL update only on cycles with load=1; the new content is visible to the scan one cycle later.
REQ-015 Prescaler SHALL count 0..DIV-1 and wrap to 0; the terminal count (DIV-1) is the slot tick.
REQ-016 Digit index SHALL advance by 1 on each slot tick and wrap from NDIG-1 to 0.
REQ-017 an, seg and dp SHALL be registered; they SHALL reflect the current index one cycle after the index changes (latency 1).
REQ-018 Decode, active-high, bit order a..g: 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70 8=7F 9=7B A=77 b=1F C=4E d=3D E=4F F=47.
REQ-019 Blanked digit: an still asserted for its slot; all seg bits and dp SHALL be inactive.
REQ-020 LZS=1: digit k>0 SHALL be blanked when its nibble and all higher nibbles are 0; digit 0 is never suppressed.
REQ-021 LZS=1: dp_in[k]=1 SHALL cancel suppression of digit k and of all digits below k.
REQ-022 Blank/suppression SHALL be evaluated from the shadow registers on the same cycle as the decode.
REQ-023 ACTIVE_LOW=1 SHALL invert an, seg and dp at the output registers only; internal logic is high-true.
REQ-024 NDIG=1: index is constant 0; an stays asserted; the prescaler still runs.
REQ-025 load coincident with a slot tick: the index advances and the shadow registers update; the digit displayed in the next slot uses the new data.

Reset
REQ-026 rst=1 SHALL clear the prescaler, the index and all shadow registers to 0.
REQ-027 During reset and on the first cycle after it, an, seg and dp SHALL be all inactive (all 1s when ACTIVE_LOW=1).
REQ-028 After reset release, digit 0 SHALL be displayed from the second cycle onward; reset asserted mid-scan SHALL abort the slot with no partial-state carry-over.

Verification (NDIG=4, DIV=4, ACTIVE_LOW=1 unless stated)
REQ-029 Reset, load value=16'h1234 -> an sequence 1110,1101,1011,0111 repeating every 16 cycles; seg = ~30,~6D,~79,~33 for 4,3,2,1 in digit order 0..3, i.e. ~33,~79,~6D,~30.
REQ-030 All 16 nibbles swept on digit 0 -> seg equals the inverse of the REQ-018 table for each nibble.
REQ-031 LZS=1, value=16'h0050 -> digits 3 and 2 blank (seg=7F); digit 1 shows 5 (~5B); digit 0 shows 0 (~7E).
REQ-032 LZS=1, value=16'h0000, dp_in=4'b0100 -> digits 2..0 display 0; dp active on digit 2 only; digit 3 blank.
REQ-033 rst pulsed during the digit-2 slot -> outputs all 1s the next cycle, index restarts at 0, and the prescaler restarts at 0.
REQ-034 load asserted on the slot-tick cycle with value=16'hFFFF -> the next displayed digit shows F (~47) with no glitch value.
